array_count_unit: RTL and testbench

- Multi-cycle scan engine for the heap arrays. It reads one element per cycle from one fixed-size heap area.
- It compares each element against a key and returns either a match count or the 1-based index of the first match.
- It is the parametrised successor of the single-cycle arrayCountGreater step. It adds selectable compare modes, a length bound, and a start/done handshake, and it sits between the instruction sequencer and the heap memory read port.

---
 rtl/array_count_pkg.sv | 30 +++
 rtl/array_count_cmp.sv | 31 +++
 rtl/array_count_unit.sv | 181 ++++++++++++++++++
 tb/tb_array_count_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/array_count_pkg.sv
// array_count_pkg
//   Shared types and default sizes for the heap array scan engine and its
//   compare unit.
//   Optional feature macro used by array_count_unit: ARRAY_COUNT_EARLY_EXIT_EN.
package array_count_pkg;

  localparam int DEF_WIDTH   = 12;
  localparam int DEF_NAREA   = 10;
  localparam int DEF_NARRAYS = 20;

  typedef enum logic [1:0] {
    COUNT_GT = 2'b00,
    COUNT_LT = 2'b01,
    INDEX_EQ = 2'b10,
    INDEX_GT = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SCAN  = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Index modes report the first match position instead of a count.
  function automatic logic is_index_op(input op_t op);
    return (op == INDEX_EQ) || (op == INDEX_GT);
  endfunction

endpackage

// File: rtl/array_count_cmp.sv
// array_count_cmp
//   Combinational element-vs-key compare for the array scan units.
//   All comparisons are unsigned, full width.
// Ports:
//   op    in  compare mode (op_t)
//   data  in  heap element
//   key   in  comparison value
//   match out element satisfies the mode's predicate
module array_count_cmp
  import array_count_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] key,
  output logic             match
);

  always_comb begin
    match = 1'b0;
    case (op)
      COUNT_GT: match = (data > key);
      COUNT_LT: match = (data < key);
      INDEX_EQ: match = (data == key);
      INDEX_GT: match = (data > key);
      default:  match = 1'b0;
    endcase
  end

endmodule

// File: rtl/array_count_unit.sv
// array_count_unit
//   Multi-cycle scan engine over one fixed-size heap array area. Reads one
//   element per cycle, compares it against a key and returns either a match
//   count or the 1-based index of the first match (0 = none).
//   Optional feature: ARRAY_COUNT_EARLY_EXIT_EN -- index modes stop reading
//   and finish one cycle after the first match is seen.
// Ports:
//   clock, reset      clock and synchronous active-high reset
//   start             scan request, accepted only in IDLE
//   op                00 COUNT_GT, 01 COUNT_LT, 10 INDEX_EQ, 11 INDEX_GT
//   array_id          array area to scan (base = array_id*NAREA)
//   len               elements to scan, clamped to NAREA
//   key               comparison value
//   rd_en, rd_addr    heap read request
//   rd_data           heap data, valid the cycle after rd_en
//   busy              scan in progress
//   done              one-cycle completion pulse
//   result            count or first-match index, held between scans
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing one read per cycle, comparing the previous element
// DRAIN | no read; comparing the final element
// DONE  | done pulse, result valid
module array_count_unit
  import array_count_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int NAREA   = DEF_NAREA,
  parameter  int NARRAYS = DEF_NARRAYS,
  localparam int ADDR_W  = $clog2(NARRAYS*NAREA),
  localparam int CNT_W   = $clog2(NAREA+1),
  localparam int AID_W   = $clog2(NARRAYS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [AID_W-1:0]  array_id,
  input  logic [CNT_W-1:0]  len,
  input  logic [WIDTH-1:0]  key,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  result
);

  state_t             r_state;
  state_t             w_next;
  op_t                r_op;
  logic [ADDR_W-1:0]  r_base;
  logic [CNT_W-1:0]   r_len;
  logic [WIDTH-1:0]   r_key;
  logic [CNT_W-1:0]   r_idx;     // next element to issue
  logic [CNT_W-1:0]   r_cidx;    // element currently being compared
  logic               r_vld;     // rd_data holds a requested element
  logic [CNT_W-1:0]   r_acc;
  logic               r_found;
  logic [CNT_W-1:0]   r_result;

  logic [CNT_W-1:0]   w_len_clamp;
  logic               w_match;
  logic               w_cmp_en;
  logic               w_hit;
  logic               w_last_issue;
  logic               w_early_exit;
  logic [CNT_W-1:0]   w_acc_next;

  assign w_len_clamp  = (len > CNT_W'(NAREA)) ? CNT_W'(NAREA) : len;
  assign w_last_issue = (r_state == SCAN) && (r_idx == r_len - CNT_W'(1));
  // A read issued in the cycle the engine leaves for DONE returns while in
  // DONE/IDLE and is ignored there.
  assign w_cmp_en     = r_vld && ((r_state == SCAN) || (r_state == DRAIN));
  assign w_hit        = w_cmp_en && w_match && is_index_op(r_op) && !r_found;

`ifdef ARRAY_COUNT_EARLY_EXIT_EN
  assign w_early_exit = w_hit;
`else
  assign w_early_exit = 1'b0;
`endif

  array_count_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .op    (r_op),
    .data  (rd_data),
    .key   (r_key),
    .match (w_match)
  );

  always_comb begin
    w_acc_next = r_acc;
    if (w_cmp_en && w_match) begin
      if (!is_index_op(r_op))
        w_acc_next = r_acc + CNT_W'(1);
      else if (!r_found)
        w_acc_next = r_cidx + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    rd_en  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start)
          w_next = (w_len_clamp == '0) ? DONE : SCAN;
      end
      SCAN: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (w_early_exit)
          w_next = DONE;
        else if (w_last_issue)
          w_next = DRAIN;
      end
      DRAIN: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign rd_addr = (r_state == SCAN) ? (r_base + ADDR_W'(r_idx)) : '0;
  assign result  = r_result;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op     <= COUNT_GT;
      r_base   <= '0;
      r_len    <= '0;
      r_key    <= '0;
      r_idx    <= '0;
      r_cidx   <= '0;
      r_vld    <= 1'b0;
      r_acc    <= '0;
      r_found  <= 1'b0;
      r_result <= '0;
    end else begin
      r_vld <= rd_en;
      if ((r_state == IDLE) && start) begin
        r_op    <= op_t'(op);
        r_base  <= ADDR_W'(array_id) * ADDR_W'(NAREA);
        r_len   <= w_len_clamp;
        r_key   <= key;
        r_idx   <= '0;
        r_cidx  <= '0;
        r_acc   <= '0;
        r_found <= 1'b0;
      end else begin
        if (rd_en)
          r_idx <= r_idx + CNT_W'(1);
        if (w_cmp_en) begin
          r_cidx  <= r_cidx + CNT_W'(1);
          r_acc   <= w_acc_next;
          r_found <= r_found | w_hit;
        end
      end
      // Zero-length scans go straight from IDLE to DONE with a zero result.
      if ((w_next == DONE) && (r_state != DONE))
        r_result <= (r_state == IDLE) ? '0 : w_acc_next;
    end
  end

endmodule

// File: tb/tb_array_count_unit.sv
module tb_array_count_unit;
  import array_count_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  array_id;
  logic [3:0]  len;
  logic [11:0] key;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [11:0] rd_data;
  logic        busy;
  logic        done;
  logic [3:0]  result;

  int checks = 0;
  int errors = 0;

  int s_res, s_lat, s_nrd, s_amin, s_amax, s_dw;
  int n_done;

  logic [11:0] mem [0:199];

`ifdef ARRAY_COUNT_EARLY_EXIT_EN
  localparam int L2 = 4;  localparam int N2 = 3;  localparam int M2 = 2;
  localparam int L4 = 5;  localparam int N4 = 4;  localparam int M4 = 13;
`else
  localparam int L2 = 12; localparam int N2 = 10; localparam int M2 = 9;
  localparam int L4 = 12; localparam int N4 = 10; localparam int M4 = 19;
`endif

  array_count_unit dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .array_id (array_id),
    .len      (len),
    .key      (key),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a scan and follows it until one cycle past done (or a bound).
  // ign > 0 re-asserts start with different operands in cycle t+ign.
  task automatic run_scan(input logic [1:0] o, input logic [4:0] aid,
                          input logic [3:0] l, input logic [11:0] k,
                          input int ign);
    @(negedge clock);
    op = o; array_id = aid; len = l; key = k; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    s_res = -1; s_lat = -1; s_nrd = 0; s_amin = 999; s_amax = -1; s_dw = 0;
    for (int n = 1; n <= 40 && !(s_lat >= 0 && n > s_lat + 1); n++) begin
      if (rd_en) begin
        s_nrd++;
        if (int'(rd_addr) < s_amin) s_amin = int'(rd_addr);
        if (int'(rd_addr) > s_amax) s_amax = int'(rd_addr);
      end
      if (done) begin
        s_dw++;
        if (s_lat < 0) begin
          s_lat = n;
          s_res = int'(result);
        end
      end
      if (n == ign) begin
        start = 1'b1; op = 2'b10; key = 12'd100; len = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; array_id = '0; len = '0; key = '0;
    for (int i = 0; i < 200; i++) mem[i] = 12'd0;
    mem[0] = 12'd10; mem[1] = 12'd20; mem[2] = 12'd30;
    mem[10] = 12'd5; mem[11] = 12'd5; mem[12] = 12'd7; mem[13] = 12'd7;

    repeat (3) @(negedge clock);
    chk("rst_busy",   int'(busy),    0);
    chk("rst_done",   int'(done),    0);
    chk("rst_rd_en",  int'(rd_en),   0);
    chk("rst_rd_addr",int'(rd_addr), 0);
    chk("rst_result", int'(result),  0);
    reset = 1'b0;

    // 1: COUNT_GT key 15 on [10,20,30,0...]
    run_scan(2'b00, 5'd0, 4'd10, 12'd15, 0);
    chk("t1_result", s_res, 2);
    chk("t1_latency", s_lat, 12);
    chk("t1_nreads", s_nrd, 10);
    chk("t1_amin", s_amin, 0);
    chk("t1_amax", s_amax, 9);
    chk("t1_done_width", s_dw, 1);

    // 2: INDEX_GT key 15
    run_scan(2'b11, 5'd0, 4'd10, 12'd15, 0);
    chk("t2_result", s_res, 2);
    chk("t2_latency", s_lat, L2);
    chk("t2_nreads", s_nrd, N2);
    chk("t2_amax", s_amax, M2);

    // 3: COUNT_LT key 15 with short, full and over-long len
    run_scan(2'b01, 5'd0, 4'd3, 12'd15, 0);
    chk("t3a_result", s_res, 1);
    chk("t3a_latency", s_lat, 5);
    chk("t3a_nreads", s_nrd, 3);
    run_scan(2'b01, 5'd0, 4'd10, 12'd15, 0);
    chk("t3b_result", s_res, 8);
    run_scan(2'b01, 5'd0, 4'd15, 12'd15, 0);
    chk("t3c_result", s_res, 8);
    chk("t3c_latency", s_lat, 12);
    chk("t3c_nreads", s_nrd, 10);
    chk("t3c_amax", s_amax, 9);

    // 4: INDEX_EQ on array 1 = [5,5,7,7,0...]
    run_scan(2'b10, 5'd1, 4'd10, 12'd7, 0);
    chk("t4a_result", s_res, 3);
    chk("t4a_amin", s_amin, 10);
    chk("t4a_latency", s_lat, L4);
    chk("t4a_nreads", s_nrd, N4);
    chk("t4a_amax", s_amax, M4);
    run_scan(2'b10, 5'd1, 4'd10, 12'd99, 0);
    chk("t4b_result", s_res, 0);
    chk("t4b_latency", s_lat, 12);
    run_scan(2'b10, 5'd1, 4'd0, 12'd7, 0);
    chk("t4c_result", s_res, 0);
    chk("t4c_latency", s_lat, 1);
    chk("t4c_nreads", s_nrd, 0);

    // 5: second start during the scan is ignored
    run_scan(2'b00, 5'd0, 4'd10, 12'd0, 3);
    chk("t5_result", s_res, 3);
    chk("t5_latency", s_lat, 12);
    chk("t5_nreads", s_nrd, 10);

    // 5b: reset in the middle of a scan
    @(negedge clock);
    op = 2'b00; array_id = 5'd0; len = 4'd10; key = 12'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("t5b_busy_before", int'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("t5b_busy",    int'(busy),    0);
    chk("t5b_rd_en",   int'(rd_en),   0);
    chk("t5b_rd_addr", int'(rd_addr), 0);
    chk("t5b_result",  int'(result),  0);
    chk("t5b_done",    int'(done),    0);
    reset = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(negedge clock);
      if (done || rd_en) n_done++;
    end
    chk("t5b_no_activity", n_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
